// File: rtl/instruction_decoder_wide.sv
// instruction_decoder_wide: registers fetched instruction bytes and decodes them into datapath controls
// Optional feature macro: ID_LONG_IMM_EN enables the multi-byte LOADW immediate sequencer.
// Ports:
//   clk_i          rising-edge clock
//   reset_n_i      asynchronous active-low reset
//   next_instr_i   byte from program memory
//   instr_valid_i  next_instr_i is valid this cycle
//   jmp_o          unconditional jump
//   jmp_nz_o       conditional jump (taken if ALU not-zero)
//   ir_nibble_o    ir[3:0]
//   imm_data_o     assembled LOADW immediate (little-endian)
//   i_sel_o        0: i loads from bus, 1: i increment path
//   x_sel_o        ir[4]
//   y_sel_o        ir[3]
//   source_sel_o   0-7 reg by code, 8 ir_nibble, 9 i_pins, 10 zero, 11 imm_data
//   reg_en_o       bit n = reg code n (bit4 = r), bit8 = o_reg
//   ir_o           instruction register
//   imm_busy_o     LOADW sequence in progress
module instruction_decoder_wide #(
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic [7:0]        next_instr_i,
    input  logic              instr_valid_i,
    output logic              jmp_o,
    output logic              jmp_nz_o,
    output logic [3:0]        ir_nibble_o,
    output logic [DATA_W-1:0] imm_data_o,
    output logic              i_sel_o,
    output logic              x_sel_o,
    output logic              y_sel_o,
    output logic [3:0]        source_sel_o,
    output logic [8:0]        reg_en_o,
    output logic [7:0]        ir_o,
    output logic              imm_busy_o
);
    localparam int IMM_BYTES = DATA_W / 8;
    localparam int CNT_W = $clog2(IMM_BYTES + 1);
    logic [7:0] ir_q;
    logic       ir_valid_q;
    logic       ir_ld;
    logic       busy;
    logic       commit;
    // Destination code to enable mask: code 4 as a destination is o_reg, dm (7) also strobes i.
    function automatic logic [8:0] dst_en(input logic [2:0] d);
        return ((d == 3'd4) ? 9'h100 : (9'h001 << d)) | ((d == 3'd7) ? 9'h040 : 9'h000);
    endfunction
`ifdef ID_LONG_IMM_EN
    typedef enum logic [1:0] {EXEC, COLLECT, COMMIT} state_t;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              is_loadw;
    assign is_loadw = ir_valid_q && (ir_q[7:3] == 5'b11111);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        imm_d   = imm_q;
        ir_ld   = 1'b0;
        busy    = 1'b0;
        commit  = 1'b0;
        case (state_q)
            EXEC:    begin busy = is_loadw; ir_ld = !is_loadw; end
            COLLECT: busy = 1'b1;
            COMMIT:  begin commit = 1'b1; ir_ld = 1'b1; state_d = EXEC; cnt_d = '0; end
            default: state_d = EXEC;
        endcase
        if (busy && instr_valid_i) begin
            for (int b = 0; b < IMM_BYTES; b++)
                if (cnt_q == CNT_W'(b)) imm_d[b*8 +: 8] = next_instr_i;
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CNT_W'(IMM_BYTES - 1)) ? COMMIT : COLLECT;
        end
    end
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= EXEC;
            cnt_q   <= '0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            imm_q   <= imm_d;
        end
    end
    assign imm_data_o = imm_q;
`else
    assign ir_ld      = 1'b1;
    assign busy       = 1'b0;
    assign commit     = 1'b0;
    assign imm_data_o = '0;
`endif
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
        end else if (ir_ld) begin
            ir_q       <= next_instr_i;
            ir_valid_q <= instr_valid_i;
        end
    end
    // Decode defaults are the NOP values; without the LOADW feature 1111_1xxx falls into JNZ.
    always_comb begin
        reg_en_o     = '0;
        source_sel_o = 4'd8;
        i_sel_o      = 1'b1;
        jmp_o        = 1'b0;
        jmp_nz_o     = 1'b0;
        x_sel_o      = ir_q[4];
        y_sel_o      = ir_q[3];
        if (!reset_n_i) begin
            reg_en_o     = 9'h1FF;
            source_sel_o = 4'd10;
            i_sel_o      = 1'b0;
            x_sel_o      = 1'b0;
            y_sel_o      = 1'b0;
        end else if (commit) begin
            reg_en_o     = dst_en(ir_q[2:0]);
            source_sel_o = 4'd11;
            i_sel_o      = ir_q[2:0] != 3'd6;
        end else if (ir_valid_q && !busy) begin
            if (!ir_q[7]) begin
                reg_en_o = dst_en(ir_q[6:4]);
                i_sel_o  = ir_q[6:4] != 3'd6;
            end else if (!ir_q[6]) begin
                reg_en_o     = dst_en(ir_q[5:3]) |
                               ((ir_q[2:0] == 3'd7 && ir_q[5:3] != 3'd6) ? 9'h040 : 9'h000);
                source_sel_o = (ir_q[2:0] == ir_q[5:3]) ? 4'd9 : {1'b0, ir_q[2:0]};
                i_sel_o      = ir_q[5:3] != 3'd6;
            end else if (!ir_q[5]) begin
                reg_en_o = 9'h010;
            end else if (!ir_q[4]) begin
                jmp_o = 1'b1;
            end else begin
                jmp_nz_o = 1'b1;
            end
        end
    end
    assign imm_busy_o  = busy;
    assign ir_o        = ir_q;
    assign ir_nibble_o = ir_q[3:0];
endmodule

// File: tb/tb_instruction_decoder_wide.sv
// tb_instruction_decoder_wide: directed and random checks of instruction_decoder_wide against a behavioural model
module tb_instruction_decoder_wide;
    localparam int DW = 16;
    localparam int IB = DW / 8;
`ifdef ID_LONG_IMM_EN
    localparam bit LONG = 1'b1;
`else
    localparam bit LONG = 1'b0;
`endif
    localparam logic [8:0] DST_EN [8] = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h100, 9'h020, 9'h040, 9'h0C0};
    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [7:0]    next_instr = '0;
    logic          instr_valid = 1'b0;
    logic          jmp, jmp_nz, i_sel, x_sel, y_sel, imm_busy;
    logic [3:0]    ir_nibble, source_sel;
    logic [DW-1:0] imm_data;
    logic [8:0]    reg_en;
    logic [7:0]    ir;
    int total = 0;
    int bad = 0;
    logic [7:0]    m_ir = '0;
    logic          m_v = 1'b0;
    bit            m_col = 1'b0;
    bit            m_commit = 1'b0;
    int            m_n = 0;
    logic [DW-1:0] m_imm = '0;
    instruction_decoder_wide #(.DATA_W(DW)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .next_instr_i(next_instr), .instr_valid_i(instr_valid),
        .jmp_o(jmp), .jmp_nz_o(jmp_nz), .ir_nibble_o(ir_nibble), .imm_data_o(imm_data),
        .i_sel_o(i_sel), .x_sel_o(x_sel), .y_sel_o(y_sel), .source_sel_o(source_sel),
        .reg_en_o(reg_en), .ir_o(ir), .imm_busy_o(imm_busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic check_all();
        logic [8:0] e_en;
        int e_src;
        bit e_i, e_j, e_jnz, e_busy, care;
        logic [2:0] dst, src;
        e_en = '0; e_src = 8; e_i = 1'b1; e_j = 1'b0; e_jnz = 1'b0; e_busy = 1'b0; care = 1'b1;
        if (m_commit) begin
            e_en = DST_EN[m_ir[2:0]]; e_src = 11; e_i = m_ir[2:0] != 3'd6;
        end else if (m_col) begin
            e_busy = 1'b1;
        end else if (m_v) begin
            if (m_ir < 8'h80) begin
                e_en = DST_EN[m_ir[6:4]]; e_i = m_ir[6:4] != 3'd6;
            end else if (m_ir < 8'hC0) begin
                dst = m_ir[5:3]; src = m_ir[2:0];
                e_en = DST_EN[dst] | ((src == 3'd7 && dst != 3'd6) ? 9'h040 : 9'h000);
                e_src = (src == dst) ? 9 : int'(src);
                e_i = dst != 3'd6;
            end else if (m_ir < 8'hE0) begin
                e_en = 9'h010; care = 1'b0;
            end else if (m_ir < 8'hF0) begin
                e_j = 1'b1; care = 1'b0;
            end else begin
                e_jnz = 1'b1; care = 1'b0;
            end
        end
        chk("reg_en", 32'(reg_en), 32'(e_en));
        chk("jmp", 32'(jmp), 32'(e_j));
        chk("jmp_nz", 32'(jmp_nz), 32'(e_jnz));
        chk("imm_busy", 32'(imm_busy), 32'(e_busy));
        chk("ir", 32'(ir), 32'(m_ir));
        chk("ir_nibble", 32'(ir_nibble), 32'(m_ir[3:0]));
        chk("x_sel", 32'(x_sel), 32'(m_ir[4]));
        chk("y_sel", 32'(y_sel), 32'(m_ir[3]));
        chk("imm_data", 32'(imm_data), 32'(m_imm));
        if (care) begin
            chk("source_sel", 32'(source_sel), 32'(e_src));
            chk("i_sel", 32'(i_sel), 32'(e_i));
        end
    endtask
    task automatic step(input logic [7:0] b, input logic v);
        next_instr = b;
        instr_valid = v;
        @(posedge clk);
        #1;
        if (m_col) begin
            if (v) begin
                m_imm = (m_imm & ~(DW'(255) << (8 * m_n))) | (DW'(b) << (8 * m_n));
                m_n++;
                if (m_n == IB) begin m_col = 1'b0; m_commit = 1'b1; end
            end
        end else begin
            m_commit = 1'b0;
            m_ir = b;
            m_v = v;
            if (LONG && v && b >= 8'hF8) begin m_col = 1'b1; m_n = 0; end
        end
        check_all();
    endtask
    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        m_ir = '0; m_v = 1'b0; m_col = 1'b0; m_commit = 1'b0; m_n = 0; m_imm = '0;
        chk("rst_reg_en", 32'(reg_en), 32'h1FF);
        chk("rst_source_sel", 32'(source_sel), 32'd10);
        chk("rst_jmp", 32'({jmp, jmp_nz, i_sel, x_sel, y_sel, imm_busy}), 32'd0);
        chk("rst_ir", 32'(ir), 32'd0);
        chk("rst_imm", 32'(imm_data), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_reg_en", 32'(reg_en), 32'h1FF);
        reset_n = 1'b1;
    endtask
    initial begin
        #1;
        do_reset();
        if (LONG) begin
            step(8'hF9, 1'b1);
            step(8'h34, 1'b1);
            step(8'h12, 1'b1);
            chk("loadw_en", 32'(reg_en), 32'h002);
            chk("loadw_src", 32'(source_sel), 32'd11);
            chk("loadw_imm", 32'(imm_data), 32'h1234);
            step(8'hF9, 1'b1);
            step(8'h34, 1'b1);
            for (int k = 0; k < 3; k++) begin
                step(8'h00, 1'b0);
                chk("gap_busy", 32'(imm_busy), 32'd1);
            end
            step(8'h12, 1'b1);
            chk("gap_commit_src", 32'(source_sel), 32'd11);
            step(8'h00, 1'b0);
        end
        step(8'hF9, 1'b1);
        if (!LONG) begin
            chk("nolong_jnz", 32'(jmp_nz), 32'd1);
            chk("nolong_nib", 32'(ir_nibble), 32'd9);
        end
        step(8'h34, 1'b1);
        do_reset();
        step(8'h65, 1'b1);
        chk("load_i_en", 32'(reg_en), 32'h040);
        chk("load_i_isel", 32'(i_sel), 32'd0);
        step(8'h87, 1'b1);
        chk("move_dm_en", 32'(reg_en), 32'h041);
        step(8'hA4, 1'b1);
        chk("move_same_src", 32'(source_sel), 32'd9);
        step(8'hE3, 1'b1);
        step(8'hF2, 1'b1);
        step(8'hD8, 1'b1);
        step(8'h5A, 1'b0);
        chk("nop_en", 32'(reg_en), 32'd0);
        for (int k = 0; k < 400; k++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if ($urandom_range(3) == 0) b[7:3] = 5'b11111;
            if ($urandom_range(60) == 0) do_reset();
            step(b, $urandom_range(9) != 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
